// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative RISC-V M-extension unit. One shared shift/add
// (multiply) and shift/subtract (restoring divide) datapath serves all eight
// MUL/DIV/REM variants, one result bit per cycle.
//
// Handshake: start_i is sampled only in IDLE or DONE. An accepted request
// raises busy_o for XLEN cycles, then done_o pulses for exactly one cycle with
// result_o valid. result_o holds until the next DONE. start_i while busy_o is
// high is ignored. kill_i returns to IDLE from any state without a done_o
// pulse and wins over a simultaneous start_i. Divide-by-zero and signed
// overflow skip iteration and pulse done_o in the cycle after acceptance.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2:0]      OP_MUL   = 3'b000;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state;
  logic [2:0]          op_q;
  logic                neg_q;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opnd;
  logic [CW-1:0]       count;

  logic                a_sgn, b_sgn, sa, sb, neg_flag;
  logic [XLEN-1:0]     a_abs, b_abs;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_res;

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_nxt;
  logic [XLEN:0]       rem_sh;
  logic                div_ge;
  logic [XLEN-1:0]     rem_new;
  logic [2*XLEN-1:0]   div_nxt;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem_fin, fin;

  // Request decode: operand signedness, magnitudes, sign of result, shortcuts.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_i)
      3'b001:         begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010:         begin a_sgn = 1'b1; end
      3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      default:        begin a_sgn = 1'b0; b_sgn = 1'b0; end
    endcase
    sa    = a_sgn & a_i[XLEN-1];
    sb    = b_sgn & b_i[XLEN-1];
    a_abs = sa ? -a_i : a_i;
    b_abs = sb ? -b_i : b_i;
    // Remainder takes the dividend's sign; product and quotient take sa^sb.
    neg_flag = (op_i[2] & op_i[1]) ? sa : (sa ^ sb);
    div_zero = op_i[2] & (b_i == '0);
    div_ovf  = op_i[2] & ~op_i[0] & (a_i == MIN_NEG) & (b_i == ALL_ONES);
    special  = div_zero | div_ovf;
    special_res = '0;
    if (div_zero)      special_res = op_i[1] ? a_i : ALL_ONES;
    else if (div_ovf)  special_res = op_i[1] ? '0 : a_i;
  end

  // One iteration of each datapath plus the final sign fix-up and selection.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    mul_nxt = {mul_sum, acc[XLEN-1:1]};
    rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge  = rem_sh >= {1'b0, opnd};
    rem_new = div_ge ? XLEN'(rem_sh - {1'b0, opnd}) : rem_sh[XLEN-1:0];
    div_nxt = {rem_new, acc[XLEN-2:0], div_ge};
    prod    = neg_q ? -mul_nxt : mul_nxt;
    quo     = div_nxt[XLEN-1:0];
    rem_fin = div_nxt[2*XLEN-1:XLEN];
    fin     = '0;
    if (state == MUL)  fin = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1])  fin = neg_q ? -rem_fin : rem_fin;
    else               fin = neg_q ? -quo : quo;
  end

  // Control FSM with registered busy/done/result and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc      <= '0;
      opnd     <= '0;
      count    <= '0;
    end else if (kill_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          busy_o <= 1'b0;
          done_o <= 1'b0;
          if (start_i) begin
            op_q  <= op_i;
            neg_q <= neg_flag;
            acc   <= {{XLEN{1'b0}}, a_abs};
            opnd  <= b_abs;
            count <= '0;
            if (special) begin
              state    <= DONE;
              done_o   <= 1'b1;
              result_o <= special_res;
            end else begin
              state  <= op_i[2] ? DIV : MUL;
              busy_o <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        MUL, DIV: begin
          acc   <= (state == MUL) ? mul_nxt : div_nxt;
          count <= count + 1'b1;
          if (count == LAST) begin
            state    <= DONE;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            result_o <= fin;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
